// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I sequencing control unit: ALU function codes,
// access-size strobes, opcodes, FSM states and decoded operation classes.
package rv_ctrl_pkg;

  localparam logic [3:0] FS_PASS = 4'b0000;
  localparam logic [3:0] FS_ADD  = 4'b0010;
  localparam logic [3:0] FS_SUB  = 4'b0101;
  localparam logic [3:0] FS_SLL  = 4'b1101;

  localparam logic [2:0] WS_WORD = 3'b100;
  localparam logic [2:0] WS_HALF = 3'b010;
  localparam logic [2:0] WS_BYTE = 3'b001;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, LD2, ST2, ST3} state_t;

  typedef enum logic [3:0] {
    CLS_ILLEGAL, CLS_ADD, CLS_SUB, CLS_SLL, CLS_ADDI, CLS_SLLI, CLS_LUI,
    CLS_JAL, CLS_BEQ, CLS_BNE, CLS_BLT, CLS_BGE, CLS_LOAD, CLS_STORE
  } cls_t;

  // funct3[1:0] of loads/stores selects byte/half/word
  function automatic logic [2:0] size_strobe(input logic [1:0] f3);
    case (f3)
      2'b00:   return WS_BYTE;
      2'b01:   return WS_HALF;
      default: return WS_WORD;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Sign-extended RV32I immediates for every format, built from the upper
// instruction bits (the opcode field carries no immediate bits).
module imm_gen (
  input  logic [31:7] instr,
  output logic [31:0] imm_i,
  output logic [31:0] imm_s,
  output logic [31:0] imm_b,
  output logic [31:0] imm_u,
  output logic [31:0] imm_j
);

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

endmodule

// File: rtl/control_unit.sv
// Multi-cycle RV32I control unit: fetches one instruction at a time and
// sequences the datapath control word through one to three execution states.
//
// state  | meaning
// FETCH  | idle word, instr_ready=1, latch instr into IR on instr_valid
// DECODE | idle word, register rd/rs1/rs2/size/imm/class from IR
// EXEC   | main operation; last state for all but offset loads/stores
// LD2    | offset load: rd <= mem[rd] (rd already holds rs1+imm)
// ST2    | offset store: mem[rs1] <= rs2 (rs1 temporarily holds rs1+imm)
// ST3    | offset store: rs1 <= rs1-imm, restoring the base register
module control_unit
  import rv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  output logic             instr_ready,
  input  logic             V,
  input  logic             C,
  input  logic             N,
  input  logic             Z,
  output logic [AW-1:0]    waddr,
  output logic [AW-1:0]    raddr0,
  output logic [AW-1:0]    raddr1,
  output logic             MB,
  output logic [3:0]       FS,
  output logic             MD,
  output logic [2:0]       wstrobe,
  output logic             we,
  output logic [4:0]       shamnt,
  output logic [WIDTH-1:0] ConsIn,
  output logic             mem_we,
  output logic [2:0]       mem_wstrobe,
  output logic [31:0]      pc,
  output logic             illegal
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q;
  logic [4:0]  rd_q, rs1_q, rs2_q;
  logic [2:0]  size_q;
  logic [31:0] imm_q, imm_d;
  cls_t        cls_q, cls_d;
  logic        wr;

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1_f, rs2_f;
  logic [31:0] pc_plus4, pc_plus_imm;
  logic [AW-1:0] rd_a, rs1_a, rs2_a;
  logic        imm_nz, size_ok;
  logic        unused_flags;

  assign unused_flags = C;

  imm_gen u_imm_gen (
    .instr (ir_q[31:7]),
    .imm_i (imm_i),
    .imm_s (imm_s),
    .imm_b (imm_b),
    .imm_u (imm_u),
    .imm_j (imm_j)
  );

  assign opcode  = ir_q[6:0];
  assign funct3  = ir_q[14:12];
  assign funct7  = ir_q[31:25];
  assign rs1_f   = ir_q[19:15];
  assign rs2_f   = ir_q[24:20];
  assign size_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);

  always_comb begin
    cls_d = CLS_ILLEGAL;
    imm_d = imm_i;
    case (opcode)
      OPC_OP: begin
        if (funct3 == 3'b000 && funct7 == 7'b0000000)      cls_d = CLS_ADD;
        else if (funct3 == 3'b000 && funct7 == 7'b0100000) cls_d = CLS_SUB;
        else if (funct3 == 3'b001 && funct7 == 7'b0000000) cls_d = CLS_SLL;
      end
      OPC_OPIMM: begin
        if (funct3 == 3'b000)                              cls_d = CLS_ADDI;
        else if (funct3 == 3'b001 && funct7 == 7'b0000000) cls_d = CLS_SLLI;
      end
      OPC_LUI: begin
        cls_d = CLS_LUI;
        imm_d = imm_u;
      end
      OPC_JAL: begin
        cls_d = CLS_JAL;
        imm_d = imm_j;
      end
      OPC_BRANCH: begin
        imm_d = imm_b;
        case (funct3)
          3'b000:  cls_d = CLS_BEQ;
          3'b001:  cls_d = CLS_BNE;
          3'b100:  cls_d = CLS_BLT;
          3'b101:  cls_d = CLS_BGE;
          default: cls_d = CLS_ILLEGAL;
        endcase
      end
      OPC_LOAD: if (size_ok) cls_d = CLS_LOAD;
      OPC_STORE: begin
        imm_d = imm_s;
        // the offset trick borrows rs1, so it cannot alias rs2 or be x0
        if (size_ok && !(imm_s != 32'd0 && (rs1_f == rs2_f || rs1_f == 5'd0)))
          cls_d = CLS_STORE;
      end
      default: cls_d = CLS_ILLEGAL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q   <= 32'd0;
      rd_q   <= 5'd0;
      rs1_q  <= 5'd0;
      rs2_q  <= 5'd0;
      size_q <= WS_WORD;
      imm_q  <= 32'd0;
      cls_q  <= CLS_ILLEGAL;
    end else begin
      if (state_q == FETCH && instr_valid) ir_q <= instr;
      if (state_q == DECODE) begin
        rd_q   <= ir_q[11:7];
        rs1_q  <= rs1_f;
        rs2_q  <= rs2_f;
        size_q <= size_strobe(funct3[1:0]);
        imm_q  <= imm_d;
        cls_q  <= cls_d;
      end
    end
  end

  assign pc_plus4    = pc_q + 32'd4;
  assign pc_plus_imm = pc_q + imm_q;
  assign imm_nz      = (imm_q != 32'd0);
  assign rd_a        = AW'(rd_q);
  assign rs1_a       = AW'(rs1_q);
  assign rs2_a       = AW'(rs2_q);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_ready = 1'b0;
    waddr       = '0;
    raddr0      = '0;
    raddr1      = '0;
    MB          = 1'b0;
    FS          = FS_PASS;
    MD          = 1'b0;
    wstrobe     = WS_WORD;
    wr          = 1'b0;
    shamnt      = 5'd0;
    ConsIn      = '0;
    mem_we      = 1'b0;
    mem_wstrobe = WS_WORD;
    illegal     = 1'b0;
    case (state_q)
      FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = DECODE;
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        state_d = FETCH;
        pc_d    = pc_plus4;
        case (cls_q)
          CLS_ADD, CLS_SUB: begin
            waddr  = rd_a;
            raddr0 = rs1_a;
            raddr1 = rs2_a;
            FS     = (cls_q == CLS_ADD) ? FS_ADD : FS_SUB;
            wr     = 1'b1;
          end
          CLS_SLL: begin
            // the shifter only takes a constant amount; rs2's value is not routed
            waddr  = rd_a;
            raddr0 = rs1_a;
            raddr1 = rs1_a;
            FS     = FS_SLL;
            wr     = 1'b1;
          end
          CLS_ADDI: begin
            waddr  = rd_a;
            raddr0 = rs1_a;
            MB     = 1'b1;
            ConsIn = WIDTH'(imm_q);
            FS     = FS_ADD;
            wr     = 1'b1;
          end
          CLS_SLLI: begin
            waddr  = rd_a;
            raddr1 = rs1_a;
            FS     = FS_SLL;
            shamnt = imm_q[4:0];
            wr     = 1'b1;
          end
          CLS_LUI: begin
            waddr  = rd_a;
            MB     = 1'b1;
            ConsIn = WIDTH'({imm_q[31:12], 12'b0});
            FS     = FS_ADD;
            wr     = 1'b1;
          end
          CLS_JAL: begin
            waddr  = rd_a;
            MB     = 1'b1;
            ConsIn = WIDTH'(pc_plus4);
            FS     = FS_ADD;
            wr     = 1'b1;
            pc_d   = pc_plus_imm;
          end
          CLS_BEQ, CLS_BNE, CLS_BLT, CLS_BGE: begin
            raddr0 = rs1_a;
            raddr1 = rs2_a;
            FS     = FS_SUB;
            if ((cls_q == CLS_BEQ &&  Z) || (cls_q == CLS_BNE && !Z) ||
                (cls_q == CLS_BLT && (N ^ V)) || (cls_q == CLS_BGE && !(N ^ V)))
              pc_d = pc_plus_imm;
          end
          CLS_LOAD: begin
            waddr  = rd_a;
            raddr0 = rs1_a;
            wr     = 1'b1;
            if (imm_nz) begin
              MB      = 1'b1;
              ConsIn  = WIDTH'(imm_q);
              FS      = FS_ADD;
              state_d = LD2;
              pc_d    = pc_q;
            end else begin
              MD      = 1'b1;
              wstrobe = size_q;
            end
          end
          CLS_STORE: begin
            raddr0 = rs1_a;
            if (imm_nz) begin
              waddr   = rs1_a;
              MB      = 1'b1;
              ConsIn  = WIDTH'(imm_q);
              FS      = FS_ADD;
              wr      = 1'b1;
              state_d = ST2;
              pc_d    = pc_q;
            end else begin
              raddr1      = rs2_a;
              mem_we      = 1'b1;
              mem_wstrobe = size_q;
            end
          end
          default: illegal = 1'b1;
        endcase
      end
      LD2: begin
        waddr   = rd_a;
        raddr0  = rd_a;
        MD      = 1'b1;
        wstrobe = size_q;
        wr      = 1'b1;
        state_d = FETCH;
        pc_d    = pc_plus4;
      end
      ST2: begin
        raddr0      = rs1_a;
        raddr1      = rs2_a;
        mem_we      = 1'b1;
        mem_wstrobe = size_q;
        state_d     = ST3;
      end
      ST3: begin
        waddr   = rs1_a;
        raddr0  = rs1_a;
        MB      = 1'b1;
        ConsIn  = WIDTH'(imm_q);
        FS      = FS_SUB;
        wr      = 1'b1;
        state_d = FETCH;
        pc_d    = pc_plus4;
      end
      default: state_d = FETCH;
    endcase
  end

  // x0 is never written, whichever register the state targets
  assign we = wr && (waddr != '0);
  assign pc = pc_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-cycle expected control words are queued as each
// instruction is issued and compared at the falling edge as the unit steps.
module tb_control_unit;

  localparam logic [2:0] W = 3'b100, H = 3'b010, B = 3'b001;
  localparam logic [3:0] F_PASS = 4'b0000, F_ADD = 4'b0010, F_SUB = 4'b0101, F_SLL = 4'b1101;

  logic        clk, rst, instr_valid, instr_ready;
  logic [31:0] instr;
  logic        V, C, N, Z;
  logic [4:0]  waddr, raddr0, raddr1, shamnt;
  logic        MB, MD, we, mem_we, illegal;
  logic [3:0]  FS;
  logic [2:0]  wstrobe, mem_wstrobe;
  logic [31:0] ConsIn, pc;

  control_unit #(.WIDTH(32), .DEPTH(32)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .V(V), .C(C), .N(N), .Z(Z),
    .waddr(waddr), .raddr0(raddr0), .raddr1(raddr1), .MB(MB), .FS(FS),
    .MD(MD), .wstrobe(wstrobe), .we(we), .shamnt(shamnt), .ConsIn(ConsIn),
    .mem_we(mem_we), .mem_wstrobe(mem_wstrobe), .pc(pc), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rdy;
    logic [4:0]  wa, r0, r1;
    logic        mb;
    logic [3:0]  fs;
    logic        md;
    logic [2:0]  ws;
    logic        we;
    logic [4:0]  sh;
    logic [31:0] cons;
    logic        mwe;
    logic [2:0]  mws;
    logic        ill;
    logic [31:0] pc;
  } cw_t;

  typedef struct {
    string       nm;
    logic [31:0] ins;
    logic [3:0]  vcnz;
    cw_t         ex;
    logic [31:0] pc_next;
  } vec_t;

  vec_t        vecs[$];
  cw_t         sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_pc;

  function automatic cw_t cw_idle(input logic [31:0] p, input logic r);
    cw_t c;
    c = '0;
    c.ws = W; c.mws = W; c.pc = p; c.rdy = r;
    return c;
  endfunction

  function automatic cw_t ex(input logic [4:0] wa, r0, r1, input logic mb, input logic [3:0] fs,
                             input logic md, input logic [2:0] ws, input logic w, input logic [4:0] sh,
                             input logic [31:0] cons, input logic mwe, input logic [2:0] mws,
                             input logic ill);
    cw_t c;
    c = '0;
    c.wa = wa; c.r0 = r0; c.r1 = r1; c.mb = mb; c.fs = fs; c.md = md; c.ws = ws;
    c.we = w; c.sh = sh; c.cons = cons; c.mwe = mwe; c.mws = mws; c.ill = ill;
    return c;
  endfunction

  function automatic cw_t sample();
    cw_t c;
    c.rdy = instr_ready; c.wa = waddr; c.r0 = raddr0; c.r1 = raddr1; c.mb = MB; c.fs = FS;
    c.md = MD; c.ws = wstrobe; c.we = we; c.sh = shamnt; c.cons = ConsIn; c.mwe = mem_we;
    c.mws = mem_wstrobe; c.ill = illegal; c.pc = pc;
    return c;
  endfunction

  task automatic check(input string nm, input int idx, input cw_t e);
    cw_t a;
    a = sample();
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, idx, a, e);
    end
  endtask

  task automatic send(input string nm, input logic [31:0] ins);
    int n;
    n = 0;
    while (instr_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (instr_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL %s accept_timeout got ready=%b want 1", nm, instr_ready);
    end
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk);
  endtask

  // junk=1 keeps instr_valid high with an illegal word until the unit is back in FETCH
  task automatic drain(input string nm, input bit junk);
    int k;
    cw_t e;
    k = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      check(nm, k, e);
      instr_valid = junk && (sb.size() > 0);
      instr = junk ? 32'hFFFF_FFFF : 32'd0;
      k++;
    end
  endtask

  task automatic add_vec(input string nm, input logic [31:0] ins, input logic [3:0] f,
                         input cw_t e, input logic [31:0] pn);
    vec_t v;
    v.nm = nm; v.ins = ins; v.vcnz = f; v.ex = e; v.pc_next = pn;
    vecs.push_back(v);
  endtask

  task automatic run_single(input string nm, input logic [31:0] ins, input cw_t e,
                            input logic [31:0] pn, input bit junk);
    cw_t x;
    x = e;
    x.pc = exp_pc;
    sb.push_back(cw_idle(exp_pc, 1'b0));
    sb.push_back(x);
    exp_pc = pn;
    sb.push_back(cw_idle(exp_pc, 1'b1));
    send(nm, ins);
    drain(nm, junk);
  endtask

  initial begin
    cw_t e;
    rst = 1'b1; instr_valid = 1'b0; instr = 32'd0; {V, C, N, Z} = 4'b0000;

    add_vec("addi",    32'h0020_0093, 4'b0000, ex(1,0,0,1,F_ADD,0,W,1,0,32'd2,0,W,0), 32'h04);
    add_vec("slli",    32'h0010_9093, 4'b0000, ex(1,0,1,0,F_SLL,0,W,1,1,32'd0,0,W,0), 32'h08);
    add_vec("add",     32'h0020_81B3, 4'b0000, ex(3,1,2,0,F_ADD,0,W,1,0,32'd0,0,W,0), 32'h0C);
    add_vec("sub",     32'h4011_8233, 4'b0000, ex(4,3,1,0,F_SUB,0,W,1,0,32'd0,0,W,0), 32'h10);
    add_vec("sll",     32'h0073_12B3, 4'b0000, ex(5,6,6,0,F_SLL,0,W,1,0,32'd0,0,W,0), 32'h14);
    add_vec("lui",     32'h1234_5337, 4'b0000, ex(6,0,0,1,F_ADD,0,W,1,0,32'h1234_5000,0,W,0), 32'h18);
    add_vec("add_x0",  32'h0020_8033, 4'b0000, ex(0,1,2,0,F_ADD,0,W,0,0,32'd0,0,W,0), 32'h1C);
    add_vec("bad_op",  32'h0000_007F, 4'b0000, ex(0,0,0,0,F_PASS,0,W,0,0,32'd0,0,W,1), 32'h20);
    add_vec("beq_tk",  32'hFE20_8CE3, 4'b0001, ex(0,1,2,0,F_SUB,0,W,0,0,32'd0,0,W,0), 32'h18);
    add_vec("jal",     32'h0080_00EF, 4'b0000, ex(1,0,0,1,F_ADD,0,W,1,0,32'h1C,0,W,0), 32'h20);
    add_vec("beq_nt",  32'hFE20_8CE3, 4'b0100, ex(0,1,2,0,F_SUB,0,W,0,0,32'd0,0,W,0), 32'h24);
    add_vec("bne_tk",  32'hFE20_9CE3, 4'b0000, ex(0,1,2,0,F_SUB,0,W,0,0,32'd0,0,W,0), 32'h1C);
    add_vec("blt_tk",  32'hFE20_CCE3, 4'b0010, ex(0,1,2,0,F_SUB,0,W,0,0,32'd0,0,W,0), 32'h14);
    add_vec("bge_tk",  32'hFE20_DCE3, 4'b1010, ex(0,1,2,0,F_SUB,0,W,0,0,32'd0,0,W,0), 32'h0C);
    add_vec("bge_nt",  32'hFE20_DCE3, 4'b0010, ex(0,1,2,0,F_SUB,0,W,0,0,32'd0,0,W,0), 32'h10);
    add_vec("lw0",     32'h0000_A103, 4'b0000, ex(2,1,0,0,F_PASS,1,W,1,0,32'd0,0,W,0), 32'h14);
    add_vec("sb0",     32'h0030_8023, 4'b0000, ex(0,1,3,0,F_PASS,0,W,0,0,32'd0,1,B,0), 32'h18);
    add_vec("sw_alias",32'h0010_A223, 4'b0000, ex(0,0,0,0,F_PASS,0,W,0,0,32'd0,0,W,1), 32'h1C);
    add_vec("lh0",     32'h0001_1283, 4'b0000, ex(5,2,0,0,F_PASS,1,H,1,0,32'd0,0,W,0), 32'h20);
    add_vec("blt_nt",  32'hFE20_CCE3, 4'b0001, ex(0,1,2,0,F_SUB,0,W,0,0,32'd0,0,W,0), 32'h24);

    repeat (2) @(negedge clk);
    check("reset", 0, cw_idle(32'd0, 1'b1));
    rst = 1'b0;
    exp_pc = 32'd0;

    for (int i = 0; i < vecs.size(); i++) begin
      {V, C, N, Z} = vecs[i].vcnz;
      run_single(vecs[i].nm, vecs[i].ins, vecs[i].ex, vecs[i].pc_next, 1'b0);
    end
    {V, C, N, Z} = 4'b0000;

    // LW x2,4(x1): two execution states
    sb.push_back(cw_idle(exp_pc, 1'b0));
    e = ex(2,1,0,1,F_ADD,0,W,1,0,32'd4,0,W,0); e.pc = exp_pc; sb.push_back(e);
    e = ex(2,2,0,0,F_PASS,1,W,1,0,32'd0,0,W,0); e.pc = exp_pc; sb.push_back(e);
    exp_pc = exp_pc + 32'd4;
    sb.push_back(cw_idle(exp_pc, 1'b1));
    send("lw_off", 32'h0040_A103);
    drain("lw_off", 1'b0);

    // SW x3,8(x1): bump rs1, store, restore rs1
    sb.push_back(cw_idle(exp_pc, 1'b0));
    e = ex(1,1,0,1,F_ADD,0,W,1,0,32'd8,0,W,0); e.pc = exp_pc; sb.push_back(e);
    e = ex(0,1,3,0,F_PASS,0,W,0,0,32'd0,1,W,0); e.pc = exp_pc; sb.push_back(e);
    e = ex(1,1,0,1,F_SUB,0,W,1,0,32'd8,0,W,0); e.pc = exp_pc; sb.push_back(e);
    exp_pc = exp_pc + 32'd4;
    sb.push_back(cw_idle(exp_pc, 1'b1));
    send("sw_off", 32'h0030_A423);
    drain("sw_off", 1'b0);

    // instr_valid held high with junk while busy must not disturb ADDI x7,x0,5
    run_single("ignore_valid", 32'h0050_0393, ex(7,0,0,1,F_ADD,0,W,1,0,32'd5,0,W,0),
               exp_pc + 32'd4, 1'b1);

    // reset in the middle of an offset store
    sb.push_back(cw_idle(exp_pc, 1'b0));
    e = ex(1,1,0,1,F_ADD,0,W,1,0,32'd8,0,W,0); e.pc = exp_pc; sb.push_back(e);
    send("sw_rst", 32'h0030_A423);
    drain("sw_rst", 1'b0);
    @(negedge clk);
    e = ex(0,1,3,0,F_PASS,0,W,0,0,32'd0,1,W,0); e.pc = exp_pc;
    check("st2_pre_rst", 0, e);
    #2 rst = 1'b1;
    #1 check("rst_in_st2", 0, cw_idle(32'd0, 1'b1));
    @(negedge clk);
    rst = 1'b0;
    #1 check("after_rst", 0, cw_idle(32'd0, 1'b1));
    exp_pc = 32'd0;
    run_single("addi_after_rst", 32'h0020_0093, ex(1,0,0,1,F_ADD,0,W,1,0,32'd2,0,W,0),
               32'h04, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL take parameter WIDTH, default 32: datapath word width.
REQ-002 SHALL take parameter DEPTH, default 32: register count; register address width is clog2(DEPTH).
REQ-003 SHALL have port clk, input, 1: the single clock, rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port instr_valid, input, 1: instr holds a valid RV32I word.
REQ-006 SHALL have port instr, input, 32: instruction word.
REQ-007 SHALL have port instr_ready, output, 1: unit accepts instr this cycle.
REQ-008 SHALL have ports V, C, N, Z, input, 1 each: combinational datapath flags for the current control word.
REQ-009 SHALL have ports waddr, raddr0, raddr1, each output, clog2(DEPTH): datapath register addresses.
REQ-010 SHALL have ports MB (1), FS (4), MD (1), wstrobe (3), we (1), shamnt (5), ConsIn (WIDTH), all outputs: datapath control word and constant.
REQ-011 SHALL have ports mem_we (1) and mem_wstrobe (3), outputs: data-memory write enable and size.
REQ-012 SHALL have port pc, output, 32: program counter.
REQ-013 SHALL have port illegal, output, 1: one-cycle pulse on an unsupported instruction.

Function
REQ-014 SHALL implement states FETCH, DECODE, EXEC, LD2, ST2 and ST3.
REQ-015 FETCH: instr_ready=1; instr_valid=1 latches instr into IR and moves to DECODE; otherwise stays in FETCH.
REQ-016 DECODE: registers rd, rs1, rs2, funct3, the sign-extended immediate and the operation class; always moves to EXEC.
REQ-017 Idle control word in FETCH/DECODE: we=0, mem_we=0, MB=0, MD=0, FS=0000, wstrobe=100, all addresses 0, ConsIn=0.
REQ-018 ADD/SUB/SLL: waddr=rd, raddr0=rs1, raddr1=rs2, MB=0, FS=0010/0101/1101, we=1; SLL shamnt=rs2 value is not used, raddr1=rs1, shamnt=0.
REQ-019 ADDI: raddr0=rs1, MB=1, ConsIn=imm, FS=0010, we=1. SLLI: raddr1=rs1, MB=0, FS=1101, shamnt=imm[4:0], we=1.
REQ-020 LUI: raddr0=0, MB=1, ConsIn={imm[31:12],12'b0}, FS=0010, we=1.
REQ-021 JAL: rd receives pc+4 through ConsIn (raddr0=0, MB=1, FS=0010, we=1); pc becomes pc+imm.
REQ-022 BEQ/BNE/BLT/BGE: raddr0=rs1, raddr1=rs2, FS=0101, we=0; condition sampled in EXEC: Z, !Z, N^V, !(N^V); taken gives pc+imm.
REQ-023 Loads (LW/LH/LB, wstrobe 100/010/001): imm=0 uses one EXEC cycle with raddr0=rs1, MD=1, waddr=rd, we=1.
REQ-024 Loads with imm!=0: EXEC writes rd <= rs1+imm; LD2 writes rd <= mem[rd] with MD=1.
REQ-025 Stores (SW/SH/SB): imm=0 uses one EXEC cycle with raddr0=rs1, raddr1=rs2, mem_we=1, mem_wstrobe by size, we=0.
REQ-026 Stores with imm!=0: EXEC rs1 <= rs1+imm; ST2 performs the store; ST3 rs1 <= rs1-imm, restoring rs1.
REQ-027 A store with imm!=0 and (rs1==rs2 or rs1==0) SHALL be illegal.
REQ-028 rd==0 SHALL force we=0 in every state.
REQ-029 On the last execution state, pc updates (pc+4 or target, modulo 2^32) and the next state is FETCH.
REQ-030 Latency SHALL be: plain instruction 3 cycles accept-to-accept, offset load 4, offset store 5.
REQ-031 Unsupported opcode/funct: illegal=1 for one EXEC cycle, idle control word, pc+4.
REQ-032 instr_valid outside FETCH SHALL be ignored.

Reset
REQ-033 rst=1 SHALL immediately force: state FETCH, pc=0, IR=0, illegal=0, mem_we=0, and the idle control word; this applies in any state, including mid-instruction.
REQ-034 The first accept SHALL occur on the first edge after rst deasserts with instr_valid=1.

Structure
REQ-035 Shared package rv_ctrl_pkg SHALL hold the FS codes (ADD 0010, SUB 0101, SLL 1101, PASS 0000), the wstrobe codes, the opcodes and the state enum.
REQ-036 Sub-module imm_gen SHALL produce the sign-extended I/S/B/U/J immediates combinationally.

Verification
REQ-037 ADDI x1,x0,2 -> EXEC: waddr=1, raddr0=0, MB=1, ConsIn=2, FS=0010, we=1; pc 0 -> 4.
REQ-038 SLLI x1,x1,1 -> EXEC: raddr1=1, FS=1101, shamnt=1, we=1; instr_ready returns 3 cycles after accept.
REQ-039 LW x2,4(x1) -> EXEC: x2 <= x1+4 (MB=1, ConsIn=4); LD2: raddr0=2, MD=1, waddr=2, we=1.
REQ-040 SW x3,8(x1) -> EXEC: FS=0010, ConsIn=8, waddr=1; ST2: mem_we=1, mem_wstrobe=100; ST3: FS=0101, ConsIn=8, waddr=1.
REQ-041 BEQ with Z=1, imm=-8, pc=0x20 -> pc=0x18; with Z=0 -> pc=0x24.
REQ-042 rst asserted during ST2 -> mem_we=0 in the same cycle, pc=0, state FETCH, instr_ready=1 after deassert.
